gsm_cell_free_mgr: RTL and testbench
====================================

# gsm_cell_free_mgr

Cell reference tracker and free-address pool for the GSM shared cell buffer. It records the multicast owner set of every cell written by the hardware malloc stage and clears owner bits as output ports finish reading. When a cell's last owner releases it, the address goes into a show-ahead free FIFO. That FIFO feeds the malloc stage's `i_hmp_*` inputs, and the block pulses the free flag the malloc stage uses for its available-cell count.

## Interface
Parameters:
- `MWIDTH`, 4: output ports, which is also the multicast vector width.
- `LOG_MWIDTH`, 2: log2(MWIDTH).
- `AWIDTH`, 7: cell address width. The block tracks 2**AWIDTH cells.

Ports:
- `clk`  in  1  system clock. One clock only; every flop is on the rising edge.
- `clr`  in  1  synchronous, active-high reset.
- `i_gsm_wr_en`  in  1  cell allocation/write strobe from malloc.
- `i_gsm_cell_addr`  in  AWIDTH  allocated cell address.
- `i_gsm_multicast`  in  MWIDTH  owner set for that cell. Nonzero whenever `i_gsm_wr_en` is high.
- `i_rel_valid`  in  MWIDTH  per-port release request.
- `i_rel_addr`  in  MWIDTH*AWIDTH  per-port release address. Port p uses slice [p*AWIDTH +: AWIDTH].
- `o_rel_ready`  out  MWIDTH  per-port release grant.
- `o_hmp_valid`  out  1  free FIFO not empty.
- `o_hmp_addr`  out  AWIDTH  head of the free FIFO (show-ahead).
- `i_hmp_rd`  in  1  pop the free FIFO head.
- `o_bf_free_flag`  out  1  one-cycle pulse for each address returned to the pool.
- `o_free_cnt`  out  AWIDTH+1  free FIFO occupancy.
- `o_err`  out  1  sticky protocol error. Only present with the checker macro.

## Operation
- Owner table:
  - Register array `owner[2**AWIDTH][MWIDTH]`.
  - Combinational read.
  - Cleared to all-zero by `clr`.
- Allocation: when `i_gsm_wr_en` is high, `owner[i_gsm_cell_addr] <= i_gsm_multicast`.
- Release arbitration:
  - A round-robin arbiter grants at most one requesting port per cycle.
  - `o_rel_ready[p]` is high when `grant[p]` is high. A transfer occurs when `valid & ready`.
  - Ready depends combinationally on the valid inputs. A source must not make valid depend on ready.
  - The arbiter pointer holds the last granted port. On `clr` it is set to MWIDTH-1, so port 0 has first priority.
- Release update for granted port p at address a:
  - `nxt = owner[a] & ~(1<<p)`, and `owner[a] <= nxt`.
  - If `owner[a]` had bit p set and `nxt == 0`: push a into the free FIFO and set `o_bf_free_flag` on the next cycle.
  - If bit p was not set: no state change and no push. This is an error condition.
- Allocation and release to the same address in the same cycle: the allocation wins and the release is dropped (error). Different addresses are both applied.
- Free FIFO:
  - Depth 2**AWIDTH, so it cannot overflow.
  - Empty after `clr`. The malloc stage hands out the initial addresses itself.
  - Pop when `i_hmp_rd & o_hmp_valid`.
  - `i_hmp_rd` while empty is ignored (error).
  - Push and pop in the same cycle: `o_free_cnt` is unchanged. There is no empty-bypass: a push into an empty FIFO becomes visible the next cycle.
- Reset values:
  - `o_hmp_valid` = 0, `o_bf_free_flag` = 0, `o_free_cnt` = 0, `o_err` = 0.
  - `o_rel_ready` = 0 while no port requests.
  - `o_hmp_addr` is don't-care while `o_hmp_valid` = 0.
- `clr` mid-operation: all state is discarded within one cycle, including in-flight releases and FIFO contents, and no `o_bf_free_flag` pulse is emitted.

## Timing
- Release granted in cycle N:
  - Owner table updated at the N/N+1 edge.
  - `o_bf_free_flag` is high during cycle N+1.
  - The address is visible at `o_hmp_addr` in N+1 when the FIFO was empty.
- Consecutive releases of the same address see the updated owner value. There is no RMW hazard.
- Allocation takes effect at the next edge. A release of that address is legal from cycle N+1.
- Pop: the head advances at the edge after `i_hmp_rd`.
- Maximum release throughput: one per cycle across all ports.

## Configuration
- Macro: `GSM_FREE_MGR_CHECK_EN`.
- Defined: `o_err` becomes sticky-high, until `clr`, on any of:
  - release of an owner bit that is not set;
  - release dropped by an allocation collision;
  - `i_hmp_rd` while the FIFO is empty;
  - allocation to an address whose owner set is nonzero.
- Undefined: the checker logic is absent and `o_err` is tied 0. Functional behaviour is identical either way.

## Structure
- Shared package `gsm_pkg`: default `MWIDTH`/`AWIDTH`/`LOG_MWIDTH` constants, the cell-address and multicast-vector typedefs, and a onehot-to-index function.
- Sub-module `gsm_rr_arbiter`: MWIDTH-way round-robin arbiter with one-hot grant and pointer update.
- The free FIFO is inline: array plus read/write pointers plus count.

## Test plan
- Reset: hold `clr` 2 cycles, then observe. Required: `o_hmp_valid`=0, `o_free_cnt`=0, `o_bf_free_flag`=0, `o_err`=0.
- Multicast release:
  - Stimulus: alloc address 5 with owner 4'b0101; port 0 releases 5; port 2 releases 5.
  - Required: no pulse after port 0. After port 2's grant, one `o_bf_free_flag` pulse; `o_hmp_valid`=1 with `o_hmp_addr`=5 one cycle later.
- Arbitration fairness:
  - Stimulus: single-owner cells 10/11/12/13 owned by ports 0/1/2/3; all four ports assert release in the same cycle.
  - Required: grants go to 0, 1, 2, 3 on consecutive cycles; 4 pulses; pop order 10, 11, 12, 13.
- Push/pop concurrency:
  - Stimulus: free 128 addresses (`o_free_cnt`=128), then pop and push in the same cycle.
  - Required: count stays 128. Then drain to 0, after which `o_hmp_valid`=0.
- Error handling:
  - Stimulus: port 1 releases address 9 whose owner is 4'b0001.
  - Required: no push and no pulse in either build. `o_err`=1 with `GSM_FREE_MGR_CHECK_EN` defined, 0 without it.
- Mid-operation reset:
  - Stimulus: assert `clr` in the same cycle as a final-owner release.
  - Required: no pulse, FIFO empty, owner table zero.

Source files
------------

// File: rtl/gsm_pkg.sv
// Shared definitions for the GSM cell free manager: default widths,
// cell-address / multicast-vector types and a one-hot to index helper.
package gsm_pkg;

    localparam int unsigned DefMwidth    = 4;
    localparam int unsigned DefLogMwidth = 2;
    localparam int unsigned DefAwidth    = 7;

    typedef logic [DefAwidth-1:0] cell_addr_t;
    typedef logic [DefMwidth-1:0] mcast_t;

    // Index of the set bit; returns 0 for an all-zero vector.
    function automatic logic [DefLogMwidth-1:0] onehot_to_idx(input mcast_t oh);
        logic [DefLogMwidth-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(DefMwidth); i++) begin
            if (oh[i]) begin
                idx = idx | DefLogMwidth'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/gsm_cell_free_mgr_if.sv
// Bus between the hardware malloc stage / output ports and the cell free manager.
// The slave modport is the manager side; the master modport drives it.
interface gsm_cell_free_mgr_if #(
    parameter int unsigned MWIDTH = 4,
    parameter int unsigned AWIDTH = 7
);
    logic                     i_gsm_wr_en;
    logic [AWIDTH-1:0]        i_gsm_cell_addr;
    logic [MWIDTH-1:0]        i_gsm_multicast;
    logic [MWIDTH-1:0]        i_rel_valid;
    logic [MWIDTH*AWIDTH-1:0] i_rel_addr;
    logic [MWIDTH-1:0]        o_rel_ready;
    logic                     o_hmp_valid;
    logic [AWIDTH-1:0]        o_hmp_addr;
    logic                     i_hmp_rd;
    logic                     o_bf_free_flag;
    logic [AWIDTH:0]          o_free_cnt;
    logic                     o_err;

    modport slave (
        input  i_gsm_wr_en, i_gsm_cell_addr, i_gsm_multicast, i_rel_valid, i_rel_addr,
        input  i_hmp_rd,
        output o_rel_ready, o_hmp_valid, o_hmp_addr, o_bf_free_flag, o_free_cnt, o_err
    );

    modport master (
        output i_gsm_wr_en, i_gsm_cell_addr, i_gsm_multicast, i_rel_valid, i_rel_addr,
        output i_hmp_rd,
        input  o_rel_ready, o_hmp_valid, o_hmp_addr, o_bf_free_flag, o_free_cnt, o_err
    );

endinterface

// File: rtl/gsm_rr_arbiter.sv
// MWIDTH-way round-robin arbiter. The pointer holds the last granted port;
// the search starts just after it, so after clr port 0 has first priority.
module gsm_rr_arbiter #(
    parameter int unsigned MWIDTH     = 4,
    parameter int unsigned LOG_MWIDTH = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [MWIDTH-1:0] req_i,
    output logic [MWIDTH-1:0] grant_o
);

    logic [LOG_MWIDTH-1:0] ptr_q, ptr_d;

    // Find first requester after the pointer and move the pointer onto it.
    always_comb begin
        logic                  found;
        logic [LOG_MWIDTH-1:0] idx;
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= int'(MWIDTH); i++) begin
            idx = ptr_q + LOG_MWIDTH'(i);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                ptr_d        = idx;
                found        = 1'b1;
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (clr) begin
            ptr_q <= LOG_MWIDTH'(MWIDTH - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/gsm_cell_free_mgr.sv
// Cell reference tracker and free-address pool for the GSM shared cell buffer.
// Optional protocol checker enabled by defining GSM_FREE_MGR_CHECK_EN (drives o_err).
module gsm_cell_free_mgr
    import gsm_pkg::*;
#(
    parameter int unsigned MWIDTH     = DefMwidth,
    parameter int unsigned LOG_MWIDTH = DefLogMwidth,
    parameter int unsigned AWIDTH     = DefAwidth
) (
    input  logic                clk,
    input  logic                clr,
    gsm_cell_free_mgr_if.slave  mgr_io
);

    localparam int unsigned NCell = 2 ** AWIDTH;

    logic [MWIDTH-1:0]     owner_q [NCell];
    logic [AWIDTH-1:0]     fifo_q  [NCell];
    logic [AWIDTH-1:0]     wptr_q, rptr_q;
    logic [AWIDTH:0]       cnt_q, cnt_d;
    logic                  flag_q;

    logic [MWIDTH-1:0]     grant;
    logic [LOG_MWIDTH-1:0] gidx;
    logic                  rel_go, bit_set, collide, rel_apply, push, pop;
    logic [AWIDTH-1:0]     rel_a;
    logic [MWIDTH-1:0]     owner_cur, owner_nxt;

    gsm_rr_arbiter #(
        .MWIDTH     (MWIDTH),
        .LOG_MWIDTH (LOG_MWIDTH)
    ) u_arb (
        .clk     (clk),
        .clr     (clr),
        .req_i   (mgr_io.i_rel_valid),
        .grant_o (grant)
    );

    assign mgr_io.o_rel_ready = grant;

    // Decode the granted release and decide whether it frees the cell.
    always_comb begin
        gidx      = onehot_to_idx(grant);
        rel_go    = |grant;
        rel_a     = mgr_io.i_rel_addr[int'(gidx) * int'(AWIDTH) +: AWIDTH];
        owner_cur = owner_q[rel_a];
        bit_set   = owner_cur[gidx];
        owner_nxt = owner_cur & ~(MWIDTH'(1) << gidx);
        // Allocation to the same address wins; the release is dropped.
        collide   = mgr_io.i_gsm_wr_en && (mgr_io.i_gsm_cell_addr == rel_a);
        rel_apply = rel_go && bit_set && !collide;
        push      = rel_apply && (owner_nxt == '0);
        pop       = mgr_io.i_hmp_rd && (cnt_q != '0);
    end

    // Owner table: allocation writes the set, releases clear one bit.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < int'(NCell); i++) begin
                owner_q[i] <= '0;
            end
        end else begin
            if (rel_apply) begin
                owner_q[rel_a] <= owner_nxt;
            end
            if (mgr_io.i_gsm_wr_en) begin
                owner_q[mgr_io.i_gsm_cell_addr] <= mgr_io.i_gsm_multicast;
            end
        end
    end

    // Free FIFO occupancy next-state.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Free FIFO pointers, count and free-flag pulse.
    always_ff @(posedge clk) begin
        if (clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q  <= cnt_d;
            flag_q <= push;
        end
    end

    // Free FIFO storage; contents are meaningless once the pointers reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= rel_a;
        end
    end

    assign mgr_io.o_hmp_valid    = (cnt_q != '0);
    assign mgr_io.o_hmp_addr     = fifo_q[rptr_q];
    assign mgr_io.o_free_cnt     = cnt_q;
    assign mgr_io.o_bf_free_flag = flag_q;

`ifdef GSM_FREE_MGR_CHECK_EN
    logic err_q, err_d;

    // Any protocol violation sets the sticky error.
    always_comb begin
        err_d = err_q;
        if (rel_go && (!bit_set || collide))                          err_d = 1'b1;
        if (mgr_io.i_hmp_rd && (cnt_q == '0))                         err_d = 1'b1;
        if (mgr_io.i_gsm_wr_en && (owner_q[mgr_io.i_gsm_cell_addr] != '0)) err_d = 1'b1;
    end

    // Sticky error register.
    always_ff @(posedge clk) begin
        if (clr) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign mgr_io.o_err = err_q;
`else
    assign mgr_io.o_err = 1'b0;
`endif

endmodule

// File: tb/tb_gsm_cell_free_mgr.sv
// Directed self-checking bench for gsm_cell_free_mgr.
module tb_gsm_cell_free_mgr;

    localparam int unsigned MW = 4;
    localparam int unsigned AW = 7;

`ifdef GSM_FREE_MGR_CHECK_EN
    localparam logic ExpErr = 1'b1;
`else
    localparam logic ExpErr = 1'b0;
`endif

    logic clk;
    logic clr;
    int   n_checks;
    int   n_errors;

    gsm_cell_free_mgr_if #(.MWIDTH(MW), .AWIDTH(AW)) bus ();

    gsm_cell_free_mgr dut (
        .clk    (clk),
        .clr    (clr),
        .mgr_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_gsm_wr_en     = 1'b0;
        bus.i_gsm_cell_addr = '0;
        bus.i_gsm_multicast = '0;
        bus.i_rel_valid     = '0;
        bus.i_rel_addr      = '0;
        bus.i_hmp_rd        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
    endtask

    task automatic alloc(input logic [AW-1:0] a, input logic [MW-1:0] mc);
        bus.i_gsm_wr_en     = 1'b1;
        bus.i_gsm_cell_addr = a;
        bus.i_gsm_multicast = mc;
        tick();
        bus.i_gsm_wr_en     = 1'b0;
    endtask

    task automatic set_rel(input int p, input logic [AW-1:0] a);
        bus.i_rel_valid[p]          = 1'b1;
        bus.i_rel_addr[p*AW +: AW]  = a;
    endtask

    initial begin
        logic [AW-1:0] head;
        int            bad;
        n_checks = 0;
        n_errors = 0;
        clr      = 1'b0;

        // Reset state.
        do_reset();
        check("rst_valid", 32'(bus.o_hmp_valid), 0);
        check("rst_cnt", 32'(bus.o_free_cnt), 0);
        check("rst_flag", 32'(bus.o_bf_free_flag), 0);
        check("rst_err", 32'(bus.o_err), 0);
        check("rst_ready", 32'(bus.o_rel_ready), 0);

        // Multicast release: owners 0 and 2 of cell 5.
        alloc(7'd5, 4'b0101);
        set_rel(0, 7'd5);
        #1;
        check("mc_rdy0", 32'(bus.o_rel_ready), 32'h1);
        tick();
        idle_inputs();
        check("mc_noflag", 32'(bus.o_bf_free_flag), 0);
        check("mc_cnt0", 32'(bus.o_free_cnt), 0);
        set_rel(2, 7'd5);
        #1;
        check("mc_rdy2", 32'(bus.o_rel_ready), 32'h4);
        tick();
        idle_inputs();
        check("mc_flag", 32'(bus.o_bf_free_flag), 1);
        check("mc_valid", 32'(bus.o_hmp_valid), 1);
        check("mc_addr", 32'(bus.o_hmp_addr), 5);
        check("mc_cnt1", 32'(bus.o_free_cnt), 1);
        tick();
        check("mc_flag_off", 32'(bus.o_bf_free_flag), 0);

        // Arbitration fairness: four single-owner cells released together.
        do_reset();
        for (int p = 0; p < 4; p++) alloc(7'(10 + p), 4'(1 << p));
        for (int p = 0; p < 4; p++) set_rel(p, 7'(10 + p));
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rr_grant%0d", k), 32'(bus.o_rel_ready), 32'(1 << k));
            tick();
            bus.i_rel_valid[k] = 1'b0;
            check($sformatf("rr_flag%0d", k), 32'(bus.o_bf_free_flag), 1);
        end
        tick();
        check("rr_flag_off", 32'(bus.o_bf_free_flag), 0);
        check("rr_cnt", 32'(bus.o_free_cnt), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_pop%0d", k), 32'(bus.o_hmp_addr), 32'(10 + k));
            bus.i_hmp_rd = 1'b1;
            tick();
        end
        bus.i_hmp_rd = 1'b0;
        check("rr_empty", 32'(bus.o_hmp_valid), 0);

        // Push/pop concurrency at full occupancy, then drain.
        do_reset();
        for (int i = 0; i < 128; i++) alloc(7'(i), 4'b0001);
        for (int i = 0; i < 128; i++) begin
            set_rel(0, 7'(i));
            tick();
        end
        idle_inputs();
        check("pp_full", 32'(bus.o_free_cnt), 128);
        alloc(7'd5, 4'b0001);
        set_rel(0, 7'd5);
        bus.i_hmp_rd = 1'b1;
        #1;
        check("pp_head0", 32'(bus.o_hmp_addr), 0);
        tick();
        idle_inputs();
        check("pp_cnt_same", 32'(bus.o_free_cnt), 128);
        check("pp_flag", 32'(bus.o_bf_free_flag), 1);
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            head = bus.o_hmp_addr;
            if (head != ((i < 127) ? 7'(i + 1) : 7'd5)) bad++;
            bus.i_hmp_rd = 1'b1;
            tick();
        end
        bus.i_hmp_rd = 1'b0;
        check("pp_drain_order", 32'(bad), 0);
        check("pp_cnt0", 32'(bus.o_free_cnt), 0);
        check("pp_valid0", 32'(bus.o_hmp_valid), 0);
        check("pp_err", 32'(bus.o_err), 0);

        // Error: port 1 releases a cell owned only by port 0.
        do_reset();
        alloc(7'd9, 4'b0001);
        set_rel(1, 7'd9);
        #1;
        check("err_rdy", 32'(bus.o_rel_ready), 32'h2);
        tick();
        idle_inputs();
        check("err_noflag", 32'(bus.o_bf_free_flag), 0);
        check("err_cnt", 32'(bus.o_free_cnt), 0);
        check("err_flag", 32'(bus.o_err), 32'(ExpErr));

        // Mid-operation clr together with a final-owner release.
        do_reset();
        alloc(7'd20, 4'b0001);
        set_rel(0, 7'd20);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        idle_inputs();
        check("mr_flag", 32'(bus.o_bf_free_flag), 0);
        check("mr_valid", 32'(bus.o_hmp_valid), 0);
        check("mr_cnt", 32'(bus.o_free_cnt), 0);
        check("mr_err", 32'(bus.o_err), 0);
        // A cleared owner table means this release frees nothing.
        set_rel(0, 7'd20);
        tick();
        idle_inputs();
        check("mr_owner_flag", 32'(bus.o_bf_free_flag), 0);
        check("mr_owner_cnt", 32'(bus.o_free_cnt), 0);
        check("mr_owner_err", 32'(bus.o_err), 32'(ExpErr));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
